// File: rtl/sha256_padder_pkg.sv
// Shared definitions for the SHA-256 message padder: sequencer states and
// the fixed constants of the padding layout.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_PAD80 = 3'd2,
        ST_ZERO  = 3'd3,
        ST_LEN   = 3'd4,
        ST_DRAIN = 3'd5
    } sha256_state_e;

    localparam logic [7:0] SHA256_PAD_BYTE      = 8'h80;
    localparam logic [5:0] SHA256_LEN_POS       = 6'd56;
    localparam int         SHA256_WORDS_PER_BLK = 32;

endpackage

// File: rtl/sha256_padder_if.sv
// Byte-in / 16-bit-word-out streaming bus of the SHA-256 padder.
// slave is the padder side, master is the producer/consumer side.
interface sha256_padder_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_keep;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_first;
    logic        out_blk_last;
    logic        out_msg_last;

    modport slave (
        input  in_valid, in_data, in_keep, in_last, out_ready,
        output in_ready, out_valid, out_data, out_first, out_blk_last, out_msg_last
    );

    modport master (
        output in_valid, in_data, in_keep, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_blk_last, out_msg_last
    );

endinterface

// File: rtl/sha256_padder_pack16.sv
// Byte-to-word packer: an even-position byte waits in the holding register,
// the following odd-position byte completes the word in the output register
// together with its framing flags.
module sha256_pack16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_vld,
    input  logic        byte_odd,
    input  logic [7:0]  byte_data,
    input  logic        flag_first,
    input  logic        flag_blk_last,
    input  logic        flag_msg_last,
    input  logic        out_ready,
    output logic        can_accept,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_first,
    output logic        out_blk_last,
    output logic        out_msg_last
);

    logic [7:0] hold_r;
    logic       hold_vld_r;

    // An even byte only needs the holding register; an odd byte needs the output register
    assign can_accept = !hold_vld_r || !out_valid || out_ready;

    // Holding/output registers; the word and flags stay frozen until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r       <= 8'h00;
            hold_vld_r   <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 16'h0000;
            out_first    <= 1'b0;
            out_blk_last <= 1'b0;
            out_msg_last <= 1'b0;
        end else begin
            if (byte_vld && !byte_odd) begin
                hold_r     <= byte_data;
                hold_vld_r <= 1'b1;
            end
            if (byte_vld && byte_odd) begin
                out_data     <= {hold_r, byte_data};
                out_valid    <= 1'b1;
                out_first    <= flag_first;
                out_blk_last <= flag_blk_last;
                out_msg_last <= flag_msg_last;
                hold_vld_r   <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padder: passes message bytes through, then appends 0x80, zero fill
// up to block position 56 and the 64-bit big-endian bit length, emitting
// everything as 16-bit words. LEN_W must not exceed 61.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    sha256_padder_if.slave  bus,
    output logic            busy,
    output logic            err
);

    sha256_state_e    state_r;
    logic [5:0]       pos_r;
    logic [LEN_W-1:0] cnt_r;
    logic [2:0]       len_idx_r;
    logic             first_blk_r;

    logic             can_accept_s;
    logic             accept_s;
    logic             prod_s;
    logic [7:0]       prod_byte_s;
    logic [5:0]       pos_next_s;
    logic [63:0]      len64_s;
    logic [7:0]       len_byte_s;

    assign pos_next_s = pos_r + 6'd1;
    assign len64_s    = 64'({cnt_r, 3'b000});
    // Length byte 0 is the MSB: index 0 selects bits 63..56, index 7 bits 7..0
    assign len_byte_s = len64_s[{~len_idx_r, 3'b111} -: 8];
    assign bus.in_ready = (state_r == ST_DATA) && can_accept_s;

    // Byte source selection: at most one byte per cycle, only when the packer can take it
    always_comb begin
        accept_s    = 1'b0;
        prod_s      = 1'b0;
        prod_byte_s = 8'h00;
        case (state_r)
            ST_DATA: begin
                accept_s    = bus.in_valid && can_accept_s;
                prod_s      = accept_s && bus.in_keep;
                prod_byte_s = bus.in_data;
            end
            ST_PAD80: begin
                prod_s      = can_accept_s;
                prod_byte_s = SHA256_PAD_BYTE;
            end
            ST_ZERO: begin
                prod_s      = can_accept_s;
                prod_byte_s = 8'h00;
            end
            ST_LEN: begin
                prod_s      = can_accept_s;
                prod_byte_s = len_byte_s;
            end
            default: begin
                accept_s    = 1'b0;
                prod_s      = 1'b0;
                prod_byte_s = 8'h00;
            end
        endcase
    end

    // Message sequencing: state, block position, byte count and sticky wrap error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pos_r       <= 6'd0;
            cnt_r       <= '0;
            len_idx_r   <= 3'd0;
            first_blk_r <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (prod_s) begin
                pos_r <= pos_next_s;
                if (pos_r == 6'd63) begin
                    first_blk_r <= 1'b0;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r     <= ST_DATA;
                        busy        <= 1'b1;
                        pos_r       <= 6'd0;
                        cnt_r       <= '0;
                        len_idx_r   <= 3'd0;
                        first_blk_r <= 1'b1;
                        err         <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        if (bus.in_keep) begin
                            cnt_r <= cnt_r + LEN_W'(1);
                            if (&cnt_r) begin
                                err <= 1'b1;
                            end
                        end
                        if (bus.in_last) begin
                            state_r <= ST_PAD80;
                        end
                    end
                end
                ST_PAD80: begin
                    if (prod_s) begin
                        state_r <= (pos_next_s == SHA256_LEN_POS) ? ST_LEN : ST_ZERO;
                    end
                end
                ST_ZERO: begin
                    if (prod_s && (pos_next_s == SHA256_LEN_POS)) begin
                        state_r <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (prod_s) begin
                        len_idx_r <= len_idx_r + 3'd1;
                        if (len_idx_r == 3'd7) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_valid && bus.out_ready && bus.out_msg_last) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    sha256_pack16 u_pack (
        .clk           (clk),
        .rst_n         (rst_n),
        .byte_vld      (prod_s),
        .byte_odd      (pos_r[0]),
        .byte_data     (prod_byte_s),
        .flag_first    (first_blk_r && (pos_r == 6'd1)),
        .flag_blk_last (pos_r == 6'd63),
        .flag_msg_last ((state_r == ST_LEN) && (len_idx_r == 3'd7)),
        .out_ready     (bus.out_ready),
        .can_accept    (can_accept_s),
        .out_valid     (bus.out_valid),
        .out_data      (bus.out_data),
        .out_first     (bus.out_first),
        .out_blk_last  (bus.out_blk_last),
        .out_msg_last  (bus.out_msg_last)
    );

endmodule
